alu_16bit_arbiter_ctrl: RTL and testbench

//  Shares one combinational alu_16bit between two requesters and sequences it.
//  - Round-robin arbitration over valid/ready command ports.
//  - Decodes 3-bit commands into ALU controls (ainvert, bnegate, cin, op, less).
//  - Runs SLT as two ALU passes; returns result, cout and err on one response port.

---
 rtl/alu_ctrl_pkg.sv | 51 +++++
 rtl/alu_16bit.sv | 43 ++++
 rtl/rr_arb2.sv | 28 ++
 rtl/alu_16bit_arbiter_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_alu_16bit_arbiter_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared command/op encodings, FSM states and the command decoder
// for the alu_16bit arbiter/sequencer.
package alu_ctrl_pkg;

    localparam logic [2:0] CMD_AND = 3'd0;
    localparam logic [2:0] CMD_OR  = 3'd1;
    localparam logic [2:0] CMD_XOR = 3'd2;
    localparam logic [2:0] CMD_ADD = 3'd3;
    localparam logic [2:0] CMD_SUB = 3'd4;
    localparam logic [2:0] CMD_SLT = 3'd5;
    localparam logic [2:0] CMD_NOR = 3'd6;
    localparam logic [2:0] CMD_ILL = 3'd7;

    localparam logic [2:0] ALUOP_AND  = 3'b000;
    localparam logic [2:0] ALUOP_OR   = 3'b010;
    localparam logic [2:0] ALUOP_XOR  = 3'b011;
    localparam logic [2:0] ALUOP_ADD  = 3'b100;
    localparam logic [2:0] ALUOP_LESS = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SLT2 = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic       ainvert;
        logic       bnegate;
        logic       cin;
        logic [2:0] op;
    } alu_ctrl_t;

    // SLT's first pass is a plain subtraction; the illegal code decodes to all-zero controls.
    function automatic alu_ctrl_t decode(input logic [2:0] cmd);
        alu_ctrl_t c;
        c = '{ainvert: 1'b0, bnegate: 1'b0, cin: 1'b0, op: ALUOP_AND};
        case (cmd)
            CMD_AND: c = '{ainvert: 1'b0, bnegate: 1'b0, cin: 1'b0, op: ALUOP_AND};
            CMD_OR:  c = '{ainvert: 1'b0, bnegate: 1'b0, cin: 1'b0, op: ALUOP_OR};
            CMD_XOR: c = '{ainvert: 1'b0, bnegate: 1'b0, cin: 1'b0, op: ALUOP_XOR};
            CMD_ADD: c = '{ainvert: 1'b0, bnegate: 1'b0, cin: 1'b0, op: ALUOP_ADD};
            CMD_SUB: c = '{ainvert: 1'b0, bnegate: 1'b1, cin: 1'b1, op: ALUOP_ADD};
            CMD_SLT: c = '{ainvert: 1'b0, bnegate: 1'b1, cin: 1'b1, op: ALUOP_ADD};
            CMD_NOR: c = '{ainvert: 1'b1, bnegate: 1'b1, cin: 1'b0, op: ALUOP_AND};
            default: c = '{ainvert: 1'b0, bnegate: 1'b0, cin: 1'b0, op: ALUOP_AND};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_16bit.sv
// Combinational ALU shared by the arbiter: optional operand inversion,
// AND/OR/XOR, add with carry-in, and a LESS pass-through.
module alu_16bit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ainvert,
    input  logic             bnegate,
    input  logic             cin,
    input  logic             less,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH:0]   sum_s;

    // Operand conditioning and result select
    always_comb begin
        a_s    = ainvert ? ~a : a;
        b_s    = bnegate ? ~b : b;
        sum_s  = {1'b0, a_s} + {1'b0, b_s} + {{WIDTH{1'b0}}, cin};
        result = '0;
        cout   = 1'b0;
        case (op)
            ALUOP_AND:  result = a_s & b_s;
            ALUOP_OR:   result = a_s | b_s;
            ALUOP_XOR:  result = a_s ^ b_s;
            ALUOP_ADD: begin
                result = sum_s[WIDTH-1:0];
                cout   = sum_s[WIDTH];
            end
            ALUOP_LESS: result = {{(WIDTH-1){1'b0}}, less};
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way arbiter: alternates on contention when RR_EN is set,
// otherwise requester 0 always wins.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant among the valid requesters
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (RR_EN && (last_grant == 1'b0)) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_16bit_arbiter_ctrl.sv
// Shares one external alu_16bit between two requesters: arbitration,
// command decode, two-pass SLT and a single valid/ready response port.
module alu_16bit_arbiter_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter bit RR_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][2:0]       req_cmd,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_cout,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic                  alu_cin,
    output logic                  alu_ainvert,
    output logic                  alu_bnegate,
    output logic                  alu_less,
    output logic [2:0]            alu_op,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_cout,
    output logic [15:0]           op_count
);

    state_e           state_r;
    logic             last_grant_r;
    logic             id_r;
    logic             slt_r;
    logic             rsp_valid_r;
    logic             rsp_cout_r;
    logic             rsp_err_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic             alu_cin_r;
    logic             alu_ainvert_r;
    logic             alu_bnegate_r;
    logic             alu_less_r;
    logic [2:0]       alu_op_r;
    logic [15:0]      op_count_r;

    logic [1:0]       grant_s;
    logic             sel_s;
    logic             accept_s;
    logic [2:0]       cmd_s;
    alu_ctrl_t        dec_s;
    logic             res_msb_s;
    logic             ovf_s;
    logic             lt_s;
    logic             done_s;

    rr_arb2 #(
        .RR_EN(RR_EN)
    ) u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // Accept path, decode of the granted command, and the SLT sign/overflow check
    always_comb begin
        if (state_r == ST_IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
        sel_s     = grant_s[1];
        accept_s  = |req_ready;
        cmd_s     = req_cmd[sel_s];
        dec_s     = decode(cmd_s);
        res_msb_s = alu_result[WIDTH-1];
        ovf_s     = (alu_a_r[WIDTH-1] != alu_b_r[WIDTH-1]) && (res_msb_s != alu_a_r[WIDTH-1]);
        lt_s      = res_msb_s ^ ovf_s;
        done_s    = (state_r == ST_RESP) && rsp_ready;
    end

    // Sequencer FSM with registered ALU drive and response fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= 1'b1;
            id_r          <= 1'b0;
            slt_r         <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_cout_r    <= 1'b0;
            rsp_err_r     <= 1'b0;
            rsp_result_r  <= '0;
            alu_a_r       <= '0;
            alu_b_r       <= '0;
            alu_cin_r     <= 1'b0;
            alu_ainvert_r <= 1'b0;
            alu_bnegate_r <= 1'b0;
            alu_less_r    <= 1'b0;
            alu_op_r      <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        id_r          <= sel_s;
                        slt_r         <= (cmd_s == CMD_SLT);
                        alu_a_r       <= req_a[sel_s];
                        alu_b_r       <= req_b[sel_s];
                        alu_ainvert_r <= dec_s.ainvert;
                        alu_bnegate_r <= dec_s.bnegate;
                        alu_cin_r     <= dec_s.cin;
                        alu_op_r      <= dec_s.op;
                        alu_less_r    <= 1'b0;
                        rsp_cout_r    <= 1'b0;
                        if (cmd_s == CMD_ILL) begin
                            rsp_err_r    <= 1'b1;
                            rsp_result_r <= '0;
                            rsp_valid_r  <= 1'b1;
                            state_r      <= ST_RESP;
                        end else begin
                            rsp_err_r    <= 1'b0;
                            state_r      <= ST_EXEC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (slt_r) begin
                        // Second pass just forwards the computed less-than bit
                        alu_op_r   <= ALUOP_LESS;
                        alu_less_r <= lt_s;
                        state_r    <= ST_SLT2;
                    end else begin
                        rsp_result_r <= alu_result;
                        rsp_cout_r   <= (alu_op_r == ALUOP_ADD) ? alu_cout : 1'b0;
                        rsp_valid_r  <= 1'b1;
                        state_r      <= ST_RESP;
                    end
                end
                ST_SLT2: begin
                    rsp_result_r <= alu_result;
                    rsp_cout_r   <= 1'b0;
                    alu_less_r   <= 1'b0;
                    rsp_valid_r  <= 1'b1;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r  <= 1'b0;
                        last_grant_r <= id_r;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Completed-response counter, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r <= 16'd0;
        end else begin
            op_count_r <= op_count_r + {15'd0, done_s};
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = id_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_cout    = rsp_cout_r;
    assign rsp_err     = rsp_err_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_cin     = alu_cin_r;
    assign alu_ainvert = alu_ainvert_r;
    assign alu_bnegate = alu_bnegate_r;
    assign alu_less    = alu_less_r;
    assign alu_op      = alu_op_r;
    assign op_count    = op_count_r;

endmodule

// File: tb/tb_alu_16bit_arbiter_ctrl.sv
// Directed bench: round-robin controller plus a fixed-priority twin,
// each wired to its own alu_16bit, sharing the request stimulus.
module tb_alu_16bit_arbiter_ctrl;
    import alu_ctrl_pkg::*;

    localparam int W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            req_valid = 2'b00;
    logic [1:0][2:0]       req_cmd   = '0;
    logic [1:0][W-1:0]     req_a     = '0;
    logic [1:0][W-1:0]     req_b     = '0;
    logic                  rsp_ready = 1'b1;

    logic [1:0]   req_ready, f_req_ready;
    logic         rsp_valid, rsp_id, rsp_cout, rsp_err;
    logic         f_rsp_valid, f_rsp_id, f_rsp_cout, f_rsp_err;
    logic [W-1:0] rsp_result, f_rsp_result;
    logic [W-1:0] alu_a, alu_b, alu_result, f_alu_a, f_alu_b, f_alu_result;
    logic         alu_cin, alu_ainvert, alu_bnegate, alu_less, alu_cout;
    logic         f_alu_cin, f_alu_ainvert, f_alu_bnegate, f_alu_less, f_alu_cout;
    logic [2:0]   alu_op, f_alu_op;
    logic [15:0]  op_count, f_op_count;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;

    alu_16bit_arbiter_ctrl #(.WIDTH(W), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ainvert(alu_ainvert),
        .alu_bnegate(alu_bnegate), .alu_less(alu_less), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout), .op_count(op_count)
    );

    alu_16bit #(.WIDTH(W)) u_alu (
        .a(alu_a), .b(alu_b), .ainvert(alu_ainvert), .bnegate(alu_bnegate),
        .cin(alu_cin), .less(alu_less), .op(alu_op), .result(alu_result), .cout(alu_cout)
    );

    alu_16bit_arbiter_ctrl #(.WIDTH(W), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(f_req_ready),
        .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
        .rsp_result(f_rsp_result), .rsp_cout(f_rsp_cout), .rsp_err(f_rsp_err),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_cin(f_alu_cin), .alu_ainvert(f_alu_ainvert),
        .alu_bnegate(f_alu_bnegate), .alu_less(f_alu_less), .alu_op(f_alu_op),
        .alu_result(f_alu_result), .alu_cout(f_alu_cout), .op_count(f_op_count)
    );

    alu_16bit #(.WIDTH(W)) u_alu_fp (
        .a(f_alu_a), .b(f_alu_b), .ainvert(f_alu_ainvert), .bnegate(f_alu_bnegate),
        .cin(f_alu_cin), .less(f_alu_less), .op(f_alu_op), .result(f_alu_result), .cout(f_alu_cout)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One command from requester idx with rsp_ready held high; latency counted
    // from the accept cycle to the first cycle showing rsp_valid.
    task automatic run_op(input int idx, input logic [2:0] cmd, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input logic exp_cout, input logic exp_err, input int exp_lat,
                          input string tag);
        int cyc;
        @(negedge clk);
        req_cmd[idx]   = cmd;
        req_a[idx]     = a;
        req_b[idx]     = b;
        req_valid[idx] = 1'b1;
        #1;
        cyc = 0;
        while (!req_ready[idx] && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk_val({tag, ".ready"}, {30'd0, req_ready}, 32'd1 << idx);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk_val({tag, ".lat"}, cyc, exp_lat);
        chk_val({tag, ".id"}, {31'd0, rsp_id}, idx);
        chk_val({tag, ".result"}, {16'd0, rsp_result}, {16'd0, exp_res});
        chk_val({tag, ".cout"}, {31'd0, rsp_cout}, {31'd0, exp_cout});
        chk_val({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        chk_val({tag, ".count"}, {16'd0, op_count}, {16'd0, exp_count});
        chk_val({tag, ".drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got still running, want finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk_val("rst.req_ready", {30'd0, req_ready}, 32'd0);
        chk_val("rst.result", {16'd0, rsp_result}, 32'd0);
        chk_val("rst.alu_a", {16'd0, alu_a}, 32'd0);
        chk_val("rst.alu_op", {29'd0, alu_op}, 32'd0);
        chk_val("rst.count", {16'd0, op_count}, 32'd0);
        rst_n = 1'b1;

        run_op(0, CMD_ADD, 16'h000F, 16'h000E, 16'h001D, 1'b0, 1'b0, 2, "add");
        run_op(0, CMD_SUB, 16'h000F, 16'h000E, 16'h0001, 1'b1, 1'b0, 2, "sub0");
        run_op(1, CMD_SUB, 16'd1001, 16'd12341, 16'hD3B4, 1'b0, 1'b0, 2, "sub1");
        run_op(0, CMD_SLT, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 3, "slt_neg");
        run_op(1, CMD_SLT, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 1'b0, 3, "slt_ovf");

        // Back-pressured response with requester 1 waiting
        rsp_ready = 1'b0;
        @(negedge clk);
        req_cmd[0] = CMD_ADD; req_a[0] = 16'd5; req_b[0] = 16'd6; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_cmd[1] = CMD_ADD; req_a[1] = 16'd9; req_b[1] = 16'd9; req_valid[1] = 1'b1;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            chk_val("stall.valid", {31'd0, rsp_valid}, 32'd1);
            chk_val("stall.result", {16'd0, rsp_result}, 32'h000B);
            chk_val("stall.req_ready", {30'd0, req_ready}, 32'd0);
            chk_val("stall.count", {16'd0, op_count}, {16'd0, exp_count});
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        chk_val("stall.count_inc", {16'd0, op_count}, {16'd0, exp_count});
        @(negedge clk);
        chk_val("stall.count_once", {16'd0, op_count}, {16'd0, exp_count});

        run_op(0, CMD_ILL, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1, "ill");
        run_op(1, CMD_NOR, 16'h00F0, 16'h0F00, 16'hF00F, 1'b0, 1'b0, 2, "nor");
        run_op(0, CMD_AND, 16'h0FF0, 16'h3C3C, 16'h0C30, 1'b0, 1'b0, 2, "and");
        run_op(1, CMD_OR,  16'h0FF0, 16'h3C3C, 16'h3FFC, 1'b0, 1'b0, 2, "or");
        run_op(1, CMD_XOR, 16'h0FF0, 16'h3C3C, 16'h33CC, 1'b0, 1'b0, 2, "xor");
        run_op(0, CMD_ADD, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 2, "add_carry");

        // Reset while requester 1's SUB is in EXEC; last completed grant was req0
        @(negedge clk);
        req_cmd[1] = CMD_SUB; req_a[1] = 16'h1234; req_b[1] = 16'h0001; req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_count = 16'd0;
        chk_val("mid_rst.valid", {31'd0, rsp_valid}, 32'd0);
        chk_val("mid_rst.alu_a", {16'd0, alu_a}, 32'd0);
        chk_val("mid_rst.bnegate", {31'd0, alu_bnegate}, 32'd0);
        chk_val("mid_rst.count", {16'd0, op_count}, 32'd0);
        @(negedge clk);
        chk_val("mid_rst.no_rsp", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;

        // Both requesters held valid: RR alternates from req0, fixed priority stays on req0
        req_cmd[0] = CMD_ADD; req_a[0] = 16'd1; req_b[0] = 16'd1;
        req_cmd[1] = CMD_ADD; req_a[1] = 16'd3; req_b[1] = 16'd4;
        req_valid  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!rsp_valid && cyc < 10);
            if (k == 3) req_valid = 2'b00;
            chk_val("rr.valid", {31'd0, rsp_valid}, 32'd1);
            chk_val("rr.id", {31'd0, rsp_id}, k % 2);
            chk_val("rr.result", {16'd0, rsp_result}, (k % 2 == 0) ? 32'd2 : 32'd7);
            chk_val("fp.valid", {31'd0, f_rsp_valid}, 32'd1);
            chk_val("fp.id", {31'd0, f_rsp_id}, 32'd0);
            chk_val("fp.result", {16'd0, f_rsp_result}, 32'd2);
            exp_count = exp_count + 16'd1;
        end
        @(negedge clk);
        chk_val("rr.count", {16'd0, op_count}, {16'd0, exp_count});

        // Counter wrap from 0xFFFF
        @(negedge clk);
        force dut.op_count_r = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_r;
        exp_count = 16'hFFFF;
        #1;
        chk_val("wrap.preset", {16'd0, op_count}, 32'hFFFF);
        run_op(0, CMD_ADD, 16'd2, 16'd3, 16'd5, 1'b0, 1'b0, 2, "wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
